// File: rtl/ising_spin_annealer_if.sv
// rtl/ising_spin_annealer_if.sv - host-side configuration, spin-load and run-control bus
interface ising_spin_annealer_if #(
  parameter int N_SPINS = 8,
  parameter int J_W     = 4
);
  localparam int IW = $clog2(N_SPINS);

  logic                 cfg_we;
  logic [2*IW-1:0]      cfg_addr;
  logic [J_W-1:0]       cfg_data;
  logic                 spin_we;
  logic [N_SPINS-1:0]   spin_init;
  logic                 start;
  logic [7:0]           num_sweeps;
  logic [3:0]           temp0;
  logic [N_SPINS-1:0]   spins;
  logic                 busy;
  logic                 done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, spin_we, spin_init, start, num_sweeps, temp0,
    input  spins, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, spin_we, spin_init, start, num_sweeps, temp0,
    output spins, busy, done
  );
endinterface

// File: rtl/ising_spin_annealer.sv
// rtl/ising_spin_annealer.sv - sequential Ising sweep engine with LFSR noise
// Optional per-sweep noise annealing is enabled by defining ISING_ANNEAL_EN.
module ising_spin_annealer #(
  parameter int          N_SPINS   = 8,
  parameter int          J_W       = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  ising_spin_annealer_if.slave bus
);
  localparam int IW    = $clog2(N_SPINS);
  localparam int ACC_W = J_W + IW + 1;
  localparam int V_W   = ((ACC_W > 8) ? ACC_W : 8) + 1;
  localparam logic [IW-1:0] LAST = IW'(N_SPINS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, FIN} state_t;

  state_t                   state;
  logic signed [J_W-1:0]    jmat [N_SPINS*N_SPINS];
  logic [N_SPINS-1:0]       spins_q;
  logic                     busy_q;
  logic                     done_q;
  logic [IW-1:0]            i_idx;
  logic [IW-1:0]            j_idx;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               sweep_cnt;
  logic [3:0]               temp;
  logic [15:0]              lfsr;

  logic signed [J_W-1:0]    j_cur;
  logic signed [ACC_W-1:0]  j_ext;
  logic signed [ACC_W-1:0]  term;
  logic signed [7:0]        lfsr_lo;
  logic signed [7:0]        noise;
  logic signed [V_W-1:0]    v;
  logic                     v_pos;
  logic                     v_neg;
  logic [15:0]              lfsr_next;
  logic                     idle;

  assign idle      = (state == IDLE);
  assign j_cur     = jmat[{i_idx, j_idx}];
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Diagonal couplings are stored but contribute nothing to the local field.
  always_comb begin
    j_ext = {{(ACC_W-J_W){j_cur[J_W-1]}}, j_cur};
    term  = '0;
    if (i_idx != j_idx) begin
      if (spins_q[j_idx]) term = j_ext;
      else                term = -j_ext;
    end
  end

  always_comb begin
    lfsr_lo = lfsr[7:0];
    noise   = '0;
    if (temp < 4'd8) noise = lfsr_lo >>> temp;
    v     = {{(V_W-ACC_W){acc[ACC_W-1]}}, acc} + {{(V_W-8){noise[7]}}, noise};
    v_neg = v[V_W-1];
    v_pos = !v[V_W-1] && (v != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_SPINS*N_SPINS; k++) jmat[k] <= '0;
    end else if (idle && bus.cfg_we) begin
      jmat[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      spins_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      i_idx     <= '0;
      j_idx     <= '0;
      acc       <= '0;
      sweep_cnt <= '0;
      temp      <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // A spin load in the same cycle takes priority and cancels the start.
          if (bus.spin_we) begin
            spins_q <= bus.spin_init;
          end else if (bus.start) begin
            if (bus.num_sweeps != 8'd0) begin
              sweep_cnt <= bus.num_sweeps;
              temp      <= bus.temp0;
              i_idx     <= '0;
              j_idx     <= '0;
              acc       <= '0;
              busy_q    <= 1'b1;
              state     <= ACCUM;
            end else begin
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end
        ACCUM: begin
          acc   <= acc + term;
          j_idx <= j_idx + IW'(1);
          if (j_idx == LAST) state <= UPDATE;
        end
        UPDATE: begin
          lfsr <= lfsr_next;
          if (v_pos)      spins_q[i_idx] <= 1'b1;
          else if (v_neg) spins_q[i_idx] <= 1'b0;
          acc   <= '0;
          i_idx <= i_idx + IW'(1);
          state <= ACCUM;
          if (i_idx == LAST) begin
            sweep_cnt <= sweep_cnt - 8'd1;
`ifdef ISING_ANNEAL_EN
            temp <= (temp >= 4'd8) ? 4'd8 : temp + 4'd1;
`endif
            if (sweep_cnt == 8'd1) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spins = spins_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_ising_spin_annealer.sv
// tb/tb_ising_spin_annealer.sv - directed vector bench for ising_spin_annealer
module tb_ising_spin_annealer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] model_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  ising_spin_annealer_if #(.N_SPINS(8), .J_W(4)) bus ();
  ising_spin_annealer #(.N_SPINS(8), .J_W(4), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    int         kind;
    logic [7:0] init;
    logic [7:0] nsw;
    logic [7:0] exp_spins;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Expected spins for a run with an all-zero coupling matrix: only noise moves spins.
  function automatic logic [7:0] noise_only(input logic [7:0] init, input int t0, input int nsw,
                                            input logic [15:0] l0);
    logic [7:0]  s = init;
    logic [15:0] l = l0;
    int          t = t0;
    int          n;
    for (int sw = 0; sw < nsw; sw++) begin
      for (int i = 0; i < 8; i++) begin
        n = (t >= 8) ? 0 : (int'($signed(l[7:0])) >>> t);
        if (n > 0) s[i] = 1'b1;
        else if (n < 0) s[i] = 1'b0;
        l = lfsr_step(l);
      end
`ifdef ISING_ANNEAL_EN
      t = (t >= 8) ? 8 : t + 1;
`endif
    end
    return s;
  endfunction

  task automatic load_j(input int kind);
    logic [3:0] d;
    int i, j;
    for (int a = 0; a < 64; a++) begin
      i = a / 8;
      j = a % 8;
      case (kind)
        1:       d = (i == j) ? 4'h0 : 4'h1;
        2:       d = (i == j) ? 4'h0 : 4'hF;
        3:       d = 4'h8;
        4:       d = (i == j) ? 4'h8 : 4'h0;
        default: d = 4'h0;
      endcase
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 6'(a);
      bus.cfg_data = d;
      @(posedge clk); #1;
    end
    bus.cfg_we = 1'b0;
  endtask

  task automatic load_spins(input logic [7:0] s);
    bus.spin_we   = 1'b1;
    bus.spin_init = s;
    @(posedge clk); #1;
    bus.spin_we = 1'b0;
  endtask

  // Start is sampled at edge 0; cycle c is the period after edge c-1.
  task automatic do_run(input logic [7:0] nsw, input logic [3:0] t0, input bit disturb,
                        output int busy_cnt, output int done_cyc, output bit pulse_ok);
    int budget = 72 * int'(nsw) + 10;
    busy_cnt = 0;
    done_cyc = -1;
    bus.num_sweeps = nsw;
    bus.temp0      = t0;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (disturb && c == 10) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 6'h18; bus.cfg_data = 4'h8;
        bus.spin_we = 1'b1; bus.spin_init = 8'hFF;
        bus.start = 1'b1; bus.num_sweeps = 8'd1;
      end
      if (disturb && c == 11) begin
        bus.cfg_we = 1'b0; bus.spin_we = 1'b0; bus.start = 1'b0;
      end
    end
    @(negedge clk);
    pulse_ok = !bus.done && !bus.busy;
    @(posedge clk); #1;
    for (int k = 0; k < 8 * int'(nsw); k++) model_lfsr = lfsr_step(model_lfsr);
  endtask

  task automatic run_and_check(input string name, input logic [7:0] nsw, input logic [3:0] t0,
                               input bit disturb, input logic [7:0] exp_spins);
    int  bc, dc;
    bit  pk;
    do_run(nsw, t0, disturb, bc, dc, pk);
    check({name, ".busy_cycles"}, bc, 72 * int'(nsw));
    check({name, ".done_cycle"}, dc, 72 * int'(nsw) + 1);
    check({name, ".done_pulse"}, {31'd0, pk}, 32'd1);
    check({name, ".spins"}, {24'd0, bus.spins}, {24'd0, exp_spins});
  endtask

  initial begin
    logic [7:0] exp_s;
    int  bc, dc, seen_busy, seen_done;
    bit  pk;

    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.spin_we = 1'b0; bus.spin_init = '0; bus.start = 1'b0;
    bus.num_sweeps = '0; bus.temp0 = '0;

    vecs[0] = '{1, 8'h01, 8'd1, 8'h00};
    vecs[1] = '{2, 8'h00, 8'd1, 8'h0F};
    vecs[2] = '{0, 8'hA5, 8'd3, 8'hA5};
    vecs[3] = '{1, 8'hFE, 8'd1, 8'hFF};
    vecs[4] = '{1, 8'hF0, 8'd1, 8'hFF};
    vecs[5] = '{1, 8'h0F, 8'd1, 8'h00};
    vecs[6] = '{2, 8'hFF, 8'd1, 8'hF0};
    vecs[7] = '{2, 8'h00, 8'd2, 8'h0F};
    vecs[8] = '{3, 8'h00, 8'd1, 8'h0F};
    vecs[9] = '{4, 8'h5A, 8'd1, 8'h5A};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.spins", {24'd0, bus.spins}, 32'h00);
    check("reset.busy", {31'd0, bus.busy}, 32'd0);
    check("reset.done", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_lfsr = 16'hACE1;

    // First UPDATE after reset sees lfsr=ACE1: noise -31 at temp 0 clears spin 0.
    load_spins(8'h01);
    exp_s = noise_only(8'h01, 0, 1, model_lfsr);
    run_and_check("noise_seed", 8'd1, 4'd0, 1'b0, exp_s);
    check("noise_seed.s0", {31'd0, bus.spins[0]}, 32'd0);

    bus.cfg_we = 1'b1; bus.cfg_addr = 6'h01; bus.cfg_data = 4'h3;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    load_spins(8'h02);
    run_and_check("cfg_readback", 8'd1, 4'd8, 1'b0, 8'h03);

    for (int v = 0; v < 10; v++) begin
      load_j(vecs[v].kind);
      load_spins(vecs[v].init);
      run_and_check($sformatf("vec%0d", v), vecs[v].nsw, 4'd8, 1'b0, vecs[v].exp_spins);
    end

    load_spins(8'h66);
    do_run(8'd0, 4'd8, 1'b0, bc, dc, pk);
    check("zero_sweeps.busy_cycles", bc, 0);
    check("zero_sweeps.done_cycle", dc, 1);
    check("zero_sweeps.done_pulse", {31'd0, pk}, 32'd1);
    check("zero_sweeps.spins", {24'd0, bus.spins}, 32'h66);

    bus.spin_we = 1'b1; bus.spin_init = 8'h3C;
    bus.start = 1'b1; bus.num_sweeps = 8'd1; bus.temp0 = 4'd8;
    @(posedge clk); #1;
    bus.spin_we = 1'b0; bus.start = 1'b0;
    seen_busy = 0; seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy) seen_busy++;
      if (bus.done) seen_done++;
    end
    @(posedge clk); #1;
    check("start_with_load.busy", seen_busy, 0);
    check("start_with_load.done", seen_done, 0);
    check("start_with_load.spins", {24'd0, bus.spins}, 32'h3C);

    load_j(2);
    load_spins(8'h00);
    run_and_check("busy_writes", 8'd1, 4'd8, 1'b1, 8'h0F);

    load_j(1);
    load_spins(8'hA5);
    bus.num_sweeps = 8'd2; bus.temp0 = 4'd8; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    check("midrun.busy_before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrun.async_spins", {24'd0, bus.spins}, 32'h00);
    check("midrun.async_busy", {31'd0, bus.busy}, 32'd0);
    check("midrun.async_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_lfsr = 16'hACE1;
    seen_busy = 0; seen_done = 0;
    repeat (160) begin
      @(negedge clk);
      if (bus.busy) seen_busy++;
      if (bus.done) seen_done++;
    end
    @(posedge clk); #1;
    check("midrun.no_busy_after", seen_busy, 0);
    check("midrun.no_done", seen_done, 0);
    load_spins(8'hA5);
    run_and_check("midrun.j_cleared", 8'd1, 4'd8, 1'b0, 8'hA5);

    load_spins(8'h5A);
    exp_s = noise_only(8'h5A, 6, 3, model_lfsr);
    run_and_check("anneal", 8'd3, 4'd6, 1'b0, exp_s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
